obi_arbiter: RTL and testbench

Parametrised N-master to 1-slave OBI arbiter with in-order response routing. It lets several OBI initiators share one memory port, for example a core's imem and dmem sharing a unified RAM, or multiple cores sharing one data memory. It is the multi-channel successor of the core's point-to-point OBI memory ports. Each master sees a fully compliant OBI slave; the downstream port sees a single compliant master.

---
 rtl/obi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_obi_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin or fixed-priority selection,
// request locking while the slave stalls, and in-order response routing via an ID FIFO.
module obi_arbiter #(
    parameter int NbMasters      = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter int RoundRobin     = 1
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NbMasters-1:0]             m_req_i,
    output logic [NbMasters-1:0]             m_gnt_o,
    input  logic [NbMasters*AddrWidth-1:0]   m_addr_i,
    input  logic [NbMasters-1:0]             m_we_i,
    input  logic [NbMasters*DataWidth-1:0]   m_wdata_i,
    input  logic [NbMasters*DataWidth/8-1:0] m_be_i,
    output logic [NbMasters-1:0]             m_rvalid_o,
    output logic [DataWidth-1:0]             m_rdata_o,
    output logic [NbMasters-1:0]             m_err_o,
    output logic                             s_req_o,
    input  logic                             s_gnt_i,
    output logic [AddrWidth-1:0]             s_addr_o,
    output logic                             s_we_o,
    output logic [DataWidth-1:0]             s_wdata_o,
    output logic [DataWidth/8-1:0]           s_be_o,
    input  logic                             s_rvalid_i,
    input  logic [DataWidth-1:0]             s_rdata_i,
    input  logic                             s_err_i,
    output logic [$clog2(MaxOutstanding):0]  outstanding_o,
    output logic                             protocol_err_o
);
    localparam int          IdxW  = $clog2(NbMasters);
    localparam int          PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int          CntW  = $clog2(MaxOutstanding) + 1;
    localparam int          Depth = 1 << PtrW;
    localparam int          BeW   = DataWidth / 8;
    localparam int unsigned NbM   = NbMasters;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   fifo_q [Depth];
    logic [IdxW-1:0]   fifo_d [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              perr_q, perr_d;

    logic              full, empty, push, pop, any_elig;
    logic [IdxW-1:0]   sel, sel_arb, head, idx_n;
    int unsigned       idx;

    assign full  = (cnt_q == CntW'(MaxOutstanding));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    // Search starts at rr_q in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        idx      = 0;
        idx_n    = '0;
        any_elig = 1'b0;
        sel_arb  = '0;
        for (int unsigned k = 0; k < NbM; k++) begin
            idx = (RoundRobin != 0) ? 32'(rr_q) + k : k;
            if (idx >= NbM) idx = idx - NbM;
            idx_n = IdxW'(idx);
            if (!any_elig && m_req_i[idx_n] && !full) begin
                any_elig = 1'b1;
                sel_arb  = idx_n;
            end
        end
    end

    assign sel     = (state_q == LOCKED) ? lock_idx_q : sel_arb;
    assign s_req_o = (state_q == LOCKED) || any_elig;
    assign push    = s_req_o && s_gnt_i;
    assign pop     = s_rvalid_i && !empty;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_wdata_o = '0;
        s_be_o    = '0;
        if (s_req_o) begin
            s_addr_o  = m_addr_i[sel*AddrWidth +: AddrWidth];
            s_we_o    = m_we_i[sel];
            s_wdata_o = m_wdata_i[sel*DataWidth +: DataWidth];
            s_be_o    = m_be_i[sel*BeW +: BeW];
        end
    end

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = '0;
        if (push) m_gnt_o[sel] = 1'b1;
        if (pop) begin
            m_rvalid_o[head] = 1'b1;
            m_err_o[head]    = s_err_i;
        end
    end

    assign m_rdata_o      = s_rdata_i;
    assign outstanding_o  = cnt_q;
    assign protocol_err_o = perr_q;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        perr_d     = perr_q || (s_rvalid_i && empty);
        case (state_q)
            IDLE: begin
                if (s_req_o && !s_gnt_i) begin
                    state_d    = LOCKED;
                    lock_idx_d = sel;
                end
            end
            LOCKED:  if (s_gnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (push) begin
            fifo_d[wptr_q] = sel;
            wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
            if (RoundRobin != 0) rr_d = (sel == IdxW'(NbMasters - 1)) ? '0 : sel + 1'b1;
        end
        if (pop) rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_q       <= '0;
            fifo_q     <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_obi_arbiter.sv
// Scoreboard bench for obi_arbiter: a round-robin 3-master instance (depth 2) and a
// fixed-priority 2-master instance (depth 1), both checked against a queue-based model.
module tb_obi_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [2:0]  a_req, a_gnt, a_we, a_rvalid, a_err;
    logic [95:0] a_addr, a_wdata;
    logic [11:0] a_be;
    logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
    logic        a_sreq, a_sgnt, a_swe, a_srvalid, a_serr, a_perr;
    logic [3:0]  a_sbe;
    logic [1:0]  a_outst;

    logic [1:0]  b_req, b_gnt, b_we, b_rvalid, b_err;
    logic [63:0] b_addr, b_wdata;
    logic [7:0]  b_be;
    logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
    logic        b_sreq, b_sgnt, b_swe, b_srvalid, b_serr, b_perr;
    logic [3:0]  b_sbe;
    logic [0:0]  b_outst;

    obi_arbiter #(.NbMasters(3), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .RoundRobin(1)) u_a (
        .clk_i(clk), .rstn_i(rstn), .m_req_i(a_req), .m_gnt_o(a_gnt), .m_addr_i(a_addr), .m_we_i(a_we),
        .m_wdata_i(a_wdata), .m_be_i(a_be), .m_rvalid_o(a_rvalid), .m_rdata_o(a_rdata), .m_err_o(a_err),
        .s_req_o(a_sreq), .s_gnt_i(a_sgnt), .s_addr_o(a_saddr), .s_we_o(a_swe), .s_wdata_o(a_swdata),
        .s_be_o(a_sbe), .s_rvalid_i(a_srvalid), .s_rdata_i(a_srdata), .s_err_i(a_serr),
        .outstanding_o(a_outst), .protocol_err_o(a_perr));

    obi_arbiter #(.NbMasters(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(1), .RoundRobin(0)) u_b (
        .clk_i(clk), .rstn_i(rstn), .m_req_i(b_req), .m_gnt_o(b_gnt), .m_addr_i(b_addr), .m_we_i(b_we),
        .m_wdata_i(b_wdata), .m_be_i(b_be), .m_rvalid_o(b_rvalid), .m_rdata_o(b_rdata), .m_err_o(b_err),
        .s_req_o(b_sreq), .s_gnt_i(b_sgnt), .s_addr_o(b_saddr), .s_we_o(b_swe), .s_wdata_o(b_swdata),
        .s_be_o(b_sbe), .s_rvalid_i(b_srvalid), .s_rdata_i(b_srdata), .s_err_i(b_serr),
        .outstanding_o(b_outst), .protocol_err_o(b_perr));

    // stimulus state, index [dut][master]
    logic        req_s   [2][3];
    logic [31:0] addr_s  [2][3];
    logic [31:0] wdata_s [2][3];
    logic        we_s    [2][3];
    logic [3:0]  be_s    [2][3];
    logic        sgnt_s [2], srvalid_s [2], serr_s [2];
    logic [31:0] srdata_s [2];

    // reference model: in-flight master ids in acceptance order, pending (stalled) master, rr pointer
    int infl [2][$];
    int pend [2];
    int rr_m [2];
    bit perr_m [2];
    bit hs_last [2];
    int sel_last [2];

    typedef struct {
        int          d;
        logic [2:0]  gnt, rvalid, err;
        logic        sreq, swe, perr;
        logic [31:0] saddr, swdata, rdata;
        logic [3:0]  sbe;
        int          outst;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;

    function automatic int nm(input int d);
        return (d == 0) ? 3 : 2;
    endfunction
    function automatic int mo(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            infl[d].delete();
            pend[d] = -1;
            rr_m[d] = 0;
            perr_m[d] = 1'b0;
            hs_last[d] = 1'b0;
            sel_last[d] = 0;
        end
    endtask

    task automatic new_req(input int d, input int m);
        req_s[d][m]   = 1'b1;
        addr_s[d][m]  = $urandom;
        wdata_s[d][m] = $urandom;
        we_s[d][m]    = 1'($urandom_range(1, 0));
        be_s[d][m]    = 4'($urandom_range(15, 0));
    endtask

    task automatic keep_req(input int d, input int m);
        if (!req_s[d][m] || (hs_last[d] && sel_last[d] == m)) new_req(d, m);
    endtask

    task automatic randomize_dut(input int d);
        for (int m = 0; m < nm(d); m++) begin
            if (req_s[d][m]) begin
                if (hs_last[d] && sel_last[d] == m) begin
                    if ($urandom_range(1, 0) == 1) new_req(d, m);
                    else req_s[d][m] = 1'b0;
                end
            end else if ($urandom_range(9, 0) < 4) new_req(d, m);
        end
        sgnt_s[d]    = ($urandom_range(9, 0) < 6);
        srvalid_s[d] = (infl[d].size() > 0) && ($urandom_range(1, 0) == 1);
        serr_s[d]    = ($urandom_range(9, 0) < 2);
        srdata_s[d]  = $urandom;
    endtask

    task automatic drive_ports();
        for (int m = 0; m < 3; m++) begin
            a_req[m] = req_s[0][m];  a_we[m] = we_s[0][m];
            a_addr[m*32 +: 32] = addr_s[0][m];  a_wdata[m*32 +: 32] = wdata_s[0][m];
            a_be[m*4 +: 4] = be_s[0][m];
        end
        for (int m = 0; m < 2; m++) begin
            b_req[m] = req_s[1][m];  b_we[m] = we_s[1][m];
            b_addr[m*32 +: 32] = addr_s[1][m];  b_wdata[m*32 +: 32] = wdata_s[1][m];
            b_be[m*4 +: 4] = be_s[1][m];
        end
        a_sgnt = sgnt_s[0]; a_srvalid = srvalid_s[0]; a_serr = serr_s[0]; a_srdata = srdata_s[0];
        b_sgnt = sgnt_s[1]; b_srvalid = srvalid_s[1]; b_serr = serr_s[1]; b_srdata = srdata_s[1];
    endtask

    // Predict this cycle's outputs from the rules, queue them, then advance the model.
    task automatic apply();
        drive_ports();
        for (int d = 0; d < 2; d++) begin
            int   n, sel;
            bit   sreq, hs;
            exp_t e;
            n = nm(d); sel = 0; sreq = 1'b0;
            if (pend[d] >= 0) begin
                sel = pend[d]; sreq = 1'b1;
            end else if (infl[d].size() < mo(d)) begin
                for (int k = 0; k < n; k++) begin
                    int m;
                    m = (d == 0) ? (rr_m[d] + k) % n : k;
                    if (!sreq && req_s[d][m]) begin sel = m; sreq = 1'b1; end
                end
            end
            hs = sreq && sgnt_s[d];
            e.d      = d;
            e.sreq   = sreq;
            e.gnt    = hs ? 3'(1 << sel) : 3'b000;
            e.saddr  = sreq ? addr_s[d][sel] : 32'h0;
            e.swe    = sreq ? we_s[d][sel] : 1'b0;
            e.swdata = sreq ? wdata_s[d][sel] : 32'h0;
            e.sbe    = sreq ? be_s[d][sel] : 4'h0;
            e.rvalid = 3'b000;
            e.err    = 3'b000;
            if (srvalid_s[d] && infl[d].size() > 0) begin
                e.rvalid = 3'(1 << infl[d][0]);
                e.err    = serr_s[d] ? e.rvalid : 3'b000;
            end
            e.rdata = srdata_s[d];
            e.outst = infl[d].size();
            e.perr  = perr_m[d];
            expq.push_back(e);
            if (!rstn) continue;
            if (srvalid_s[d]) begin
                if (infl[d].size() > 0) void'(infl[d].pop_front());
                else perr_m[d] = 1'b1;
            end
            if (hs) begin
                infl[d].push_back(sel);
                if (d == 0) rr_m[d] = (sel + 1) % n;
            end
            pend[d]     = (sreq && !sgnt_s[d]) ? sel : -1;
            hs_last[d]  = hs;
            sel_last[d] = sel;
        end
    endtask

    task automatic check_outputs(input exp_t e, input string p,
                                 input logic [31:0] gnt, input logic sreq, input logic [31:0] saddr,
                                 input logic swe, input logic [31:0] swdata, input logic [3:0] sbe,
                                 input logic [31:0] rvalid, input logic [31:0] err, input logic [31:0] rdata,
                                 input logic [31:0] outst, input logic perr);
        cmp({p, "_gnt"},    gnt,           32'(e.gnt));
        cmp({p, "_sreq"},   32'(sreq),     32'(e.sreq));
        cmp({p, "_saddr"},  saddr,         e.saddr);
        cmp({p, "_swe"},    32'(swe),      32'(e.swe));
        cmp({p, "_swdata"}, swdata,        e.swdata);
        cmp({p, "_sbe"},    32'(sbe),      32'(e.sbe));
        cmp({p, "_rvalid"}, rvalid,        32'(e.rvalid));
        cmp({p, "_err"},    err,           32'(e.err));
        cmp({p, "_rdata"},  rdata,         e.rdata);
        cmp({p, "_outst"},  outst,         32'(e.outst));
        cmp({p, "_perr"},   32'(perr),     32'(e.perr));
    endtask

    always @(negedge clk) begin
        while (expq.size() != 0) begin
            mon_e = expq.pop_front();
            if (mon_e.d == 0)
                check_outputs(mon_e, "a", 32'(a_gnt), a_sreq, a_saddr, a_swe, a_swdata, a_sbe,
                              32'(a_rvalid), 32'(a_err), a_rdata, 32'(a_outst), a_perr);
            else
                check_outputs(mon_e, "b", 32'(b_gnt), b_sreq, b_saddr, b_swe, b_swdata, b_sbe,
                              32'(b_rvalid), 32'(b_err), b_rdata, 32'(b_outst), b_perr);
        end
    end

    task automatic cycle_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 3; m++) begin
                req_s[d][m] = 1'b0; addr_s[d][m] = '0; wdata_s[d][m] = '0; we_s[d][m] = 1'b0; be_s[d][m] = '0;
            end
            sgnt_s[d] = 1'b0; srvalid_s[d] = 1'b0; serr_s[d] = 1'b0; srdata_s[d] = '0;
        end
        model_reset();
        drive_ports();
        repeat (3) begin cycle_edge(); apply(); end
        cycle_edge(); rstn = 1'b1; apply();

        // Lock: master 1 stalls at 0x100 for three cycles, master 0 joins a cycle later
        cycle_edge();
        req_s[0][1] = 1'b1; addr_s[0][1] = 32'h100; wdata_s[0][1] = 32'h1111; we_s[0][1] = 1'b1; be_s[0][1] = 4'hF;
        sgnt_s[0] = 1'b0; apply();
        cycle_edge();
        req_s[0][0] = 1'b1; addr_s[0][0] = 32'h200; wdata_s[0][0] = 32'h2222; we_s[0][0] = 1'b0; be_s[0][0] = 4'h3;
        apply();
        cycle_edge(); apply();
        cycle_edge(); sgnt_s[0] = 1'b1; apply();
        cycle_edge(); req_s[0][1] = 1'b0; apply();
        // FIFO now full: master 0 must wait, and a same-cycle pop must not free the slot
        cycle_edge(); addr_s[0][0] = 32'h300; wdata_s[0][0] = 32'h3333; apply();
        cycle_edge(); srvalid_s[0] = 1'b1; serr_s[0] = 1'b1; srdata_s[0] = 32'hDEAD_BEEF; apply();
        cycle_edge(); srvalid_s[0] = 1'b0; serr_s[0] = 1'b0; apply();
        cycle_edge(); req_s[0][0] = 1'b0; sgnt_s[0] = 1'b0; apply();
        for (int i = 0; i < 4 && infl[0].size() > 0; i++) begin
            cycle_edge(); srvalid_s[0] = 1'b1; srdata_s[0] = $urandom; apply();
        end
        cycle_edge(); srvalid_s[0] = 1'b1; srdata_s[0] = 32'h5A5A_5A5A; apply();
        cycle_edge(); srvalid_s[0] = 1'b0; apply();

        // Fixed priority with continuous requests and one-cycle response latency
        for (int i = 0; i < 12; i++) begin
            cycle_edge();
            keep_req(1, 0); keep_req(1, 1);
            sgnt_s[1] = 1'b1;
            srvalid_s[1] = (infl[1].size() > 0);
            srdata_s[1] = $urandom;
            apply();
        end

        for (int i = 0; i < 600; i++) begin
            cycle_edge(); randomize_dut(0); randomize_dut(1); apply();
        end

        // Fill instance A to two outstanding, then reset mid-cycle
        for (int i = 0; i < 20 && infl[0].size() < 2; i++) begin
            cycle_edge();
            for (int m = 0; m < 3; m++) keep_req(0, m);
            sgnt_s[0] = 1'b1; srvalid_s[0] = 1'b0;
            randomize_dut(1);
            apply();
        end
        cycle_edge(); sgnt_s[0] = 1'b0; srvalid_s[0] = 1'b0; randomize_dut(1); apply();
        @(negedge clk); #2;
        sgnt_s[0] = 1'b0; srvalid_s[0] = 1'b1; sgnt_s[1] = 1'b0; srvalid_s[1] = 1'b0;
        drive_ports();
        rstn = 1'b0;
        #1;
        cmp("rst_a_outst",  32'(a_outst),  32'd0);
        cmp("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        cmp("rst_a_gnt",    32'(a_gnt),    32'd0);
        cmp("rst_a_perr",   32'(a_perr),   32'd0);
        cmp("rst_b_outst",  32'(b_outst),  32'd0);
        cmp("rst_b_gnt",    32'(b_gnt),    32'd0);
        cmp("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        model_reset();
        cycle_edge(); rstn = 1'b1; apply();
        cycle_edge(); srvalid_s[0] = 1'b0; apply();

        for (int i = 0; i < 150; i++) begin
            cycle_edge(); randomize_dut(0); randomize_dut(1); apply();
        end

        @(negedge clk); #1;
        cmp("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
